// File: rtl/uart_fifo_core.sv
// Register-mapped UART for the port_id/out_port bus: programmable frame and baud, TX/RX FIFOs,
// sticky error flags and loopback. Define UART_IRQ_EN to build the IRQEN register and registered irq.

module uart_fifo_core_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty,
   output logic       drop
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic        do_push, do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign rdata   = mem[rptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end
endmodule

module uart_fifo_core #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] BASE_ADDR  = 16'h0000,
   parameter int          DIV_W      = 19
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] port_id,
   input  logic [7:0]  out_port,
   input  logic        write_strobe,
   input  logic        read_strobe,
   output logic [7:0]  in_port,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
   typedef logic [DIV_W-1:0] div_t;

   function automatic div_t baud_k(input logic [3:0] idx);
      case (idx)
         4'd0:    baud_k = div_t'(333333);
         4'd1:    baud_k = div_t'(83333);
         4'd2:    baud_k = div_t'(41667);
         4'd3:    baud_k = div_t'(20833);
         4'd5:    baud_k = div_t'(5208);
         4'd6:    baud_k = div_t'(2604);
         4'd7:    baud_k = div_t'(1736);
         4'd8:    baud_k = div_t'(868);
         4'd9:    baud_k = div_t'(434);
         4'd10:   baud_k = div_t'(217);
         4'd11:   baud_k = div_t'(109);
         default: baud_k = div_t'(10417);
      endcase
   endfunction

   logic [15:0] offset;
   logic        hit, wr_data, wr_ctrl, rd_data, rd_stat;
   logic [7:0]  ctrl, status, irqen_rd, tx_head, rx_head;
   logic        tx_full, tx_fifo_empty, tx_drop, tx_pop, tx_busy, tx_empty;
   logic        rx_full, rx_empty, rx_drop, rx_push;
   logic        ferr, perr, ovf, set_ferr, set_perr;

   assign offset  = port_id - BASE_ADDR;
   assign hit     = (offset < 16'd4);
   assign wr_data = write_strobe && hit && (offset[1:0] == 2'd0);
   assign wr_ctrl = write_strobe && hit && (offset[1:0] == 2'd1);
   assign rd_data = read_strobe  && hit && (offset[1:0] == 2'd0);
   assign rd_stat = read_strobe  && hit && (offset[1:0] == 2'd2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl <= 8'h14;
         ferr <= 1'b0;
         perr <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl <= out_port;
         // A flag raised in the cycle of the STATUS read survives the clear.
         ferr <= set_ferr || (ferr && !rd_stat);
         perr <= set_perr || (perr && !rd_stat);
         ovf  <= tx_drop || rx_drop || (ovf && !rd_stat);
      end
   end

   logic [7:0] rx_shr;

   uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(wr_data), .pop(tx_pop), .wdata(out_port),
      .rdata(tx_head), .full(tx_full), .empty(tx_fifo_empty), .drop(tx_drop)
   );

   uart_fifo_core_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .pop(rd_data), .wdata(rx_shr),
      .rdata(rx_head), .full(rx_full), .empty(rx_empty), .drop(rx_drop)
   );

   // ---------------- transmitter ----------------
   uart_state_t tx_state, tx_state_n;
   div_t        tx_cnt, tx_cnt_n, tx_k, tx_k_n;
   logic [2:0]  tx_bitn, tx_bitn_n;
   logic [7:0]  tx_shr, tx_shr_n;
   logic        tx_par, tx_par_n, tx_eight, tx_eight_n, tx_pen, tx_pen_n;
   logic        tx_line, tx_line_n, tx_adv, tx_load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_k     <= '0;
         tx_bitn  <= '0;
         tx_shr   <= '0;
         tx_par   <= 1'b0;
         tx_eight <= 1'b1;
         tx_pen   <= 1'b0;
         tx_line  <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_k     <= tx_k_n;
         tx_bitn  <= tx_bitn_n;
         tx_shr   <= tx_shr_n;
         tx_par   <= tx_par_n;
         tx_eight <= tx_eight_n;
         tx_pen   <= tx_pen_n;
         tx_line  <= tx_line_n;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_k_n     = tx_k;
      tx_bitn_n  = tx_bitn;
      tx_shr_n   = tx_shr;
      tx_par_n   = tx_par;
      tx_eight_n = tx_eight;
      tx_pen_n   = tx_pen;
      tx_line_n  = 1'b1;
      tx_pop     = 1'b0;
      tx_load    = 1'b0;
      tx_adv     = (tx_cnt == tx_k - div_t'(1));
      if (tx_state != S_IDLE) tx_cnt_n = tx_adv ? '0 : tx_cnt + div_t'(1);
      case (tx_state)
         S_IDLE:  tx_load = !tx_fifo_empty;
         S_START: if (tx_adv) begin
               tx_state_n = S_DATA;
               tx_bitn_n  = '0;
            end
         S_DATA: if (tx_adv) begin
               tx_shr_n  = tx_shr >> 1;
               tx_bitn_n = tx_bitn + 3'd1;
               if (tx_bitn == {2'b11, tx_eight}) tx_state_n = tx_pen ? S_PARITY : S_STOP;
            end
         S_PARITY: if (tx_adv) tx_state_n = S_STOP;
         S_STOP: if (tx_adv) begin
               if (!tx_fifo_empty) tx_load = 1'b1;
               else                tx_state_n = S_IDLE;
            end
         default: tx_state_n = S_IDLE;
      endcase
      // Frame parameters are captured here so CTRL writes only affect later frames.
      if (tx_load) begin
         tx_pop     = 1'b1;
         tx_state_n = S_START;
         tx_cnt_n   = '0;
         tx_k_n     = baud_k(ctrl[3:0]);
         tx_eight_n = ctrl[4];
         tx_pen_n   = ctrl[5];
         tx_shr_n   = tx_head;
         tx_par_n   = ^(tx_head & {ctrl[4], 7'h7F}) ^ ctrl[6];
      end
      case (tx_state_n)
         S_START:  tx_line_n = 1'b0;
         S_DATA:   tx_line_n = tx_shr_n[0];
         S_PARITY: tx_line_n = tx_par_n;
         default:  tx_line_n = 1'b1;
      endcase
   end

   assign tx_busy  = (tx_state != S_IDLE);
   assign tx_empty = tx_fifo_empty && !tx_busy;
   assign tx       = ctrl[7] ? 1'b1 : tx_line;

   // ---------------- receiver ----------------
   uart_state_t rx_state, rx_state_n;
   div_t        rx_cnt, rx_cnt_n, rx_k, rx_k_n;
   logic [2:0]  rx_bitn, rx_bitn_n;
   logic [7:0]  rx_shr_n;
   logic        rx_eight, rx_eight_n, rx_pen, rx_pen_n, rx_ohel, rx_ohel_n;
   logic        rx_s1, rx_s2, rx_prev, rx_adv;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_k     <= '0;
         rx_bitn  <= '0;
         rx_shr   <= '0;
         rx_eight <= 1'b1;
         rx_pen   <= 1'b0;
         rx_ohel  <= 1'b0;
      end else begin
         rx_s1    <= ctrl[7] ? tx_line : rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_k     <= rx_k_n;
         rx_bitn  <= rx_bitn_n;
         rx_shr   <= rx_shr_n;
         rx_eight <= rx_eight_n;
         rx_pen   <= rx_pen_n;
         rx_ohel  <= rx_ohel_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = (rx_state == S_IDLE) ? rx_cnt : rx_cnt + div_t'(1);
      rx_k_n     = rx_k;
      rx_bitn_n  = rx_bitn;
      rx_shr_n   = rx_shr;
      rx_eight_n = rx_eight;
      rx_pen_n   = rx_pen;
      rx_ohel_n  = rx_ohel;
      rx_push    = 1'b0;
      set_ferr   = 1'b0;
      set_perr   = 1'b0;
      rx_adv     = (rx_cnt == rx_k - div_t'(1));
      case (rx_state)
         S_IDLE: if (rx_prev && !rx_s2) begin
               rx_state_n = S_START;
               rx_cnt_n   = '0;
               rx_k_n     = baud_k(ctrl[3:0]);
               rx_eight_n = ctrl[4];
               rx_pen_n   = ctrl[5];
               rx_ohel_n  = ctrl[6];
               rx_shr_n   = '0;
            end
         S_START: if (rx_cnt == (rx_k >> 1)) begin
               rx_cnt_n   = '0;
               rx_bitn_n  = '0;
               rx_state_n = rx_s2 ? S_IDLE : S_DATA;
            end
         S_DATA: if (rx_adv) begin
               rx_cnt_n          = '0;
               rx_shr_n[rx_bitn] = rx_s2;
               rx_bitn_n         = rx_bitn + 3'd1;
               if (rx_bitn == {2'b11, rx_eight}) rx_state_n = rx_pen ? S_PARITY : S_STOP;
            end
         S_PARITY: if (rx_adv) begin
               rx_cnt_n   = '0;
               set_perr   = (rx_s2 != (^rx_shr ^ rx_ohel));
               rx_state_n = S_STOP;
            end
         S_STOP: if (rx_adv) begin
               set_ferr   = !rx_s2;
               rx_push    = 1'b1;
               rx_state_n = S_IDLE;
            end
         default: rx_state_n = S_IDLE;
      endcase
   end

   // ---------------- interrupt and read mux ----------------
`ifdef UART_IRQ_EN
   logic [2:0] irqen;
   logic       irq_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irqen <= '0;
         irq_q <= 1'b0;
      end else begin
         if (write_strobe && hit && (offset[1:0] == 2'd3)) irqen <= out_port[2:0];
         irq_q <= |(irqen & {ferr || perr || ovf, tx_empty, !rx_empty});
      end
   end
   assign irq      = irq_q;
   assign irqen_rd = {5'b0, irqen};
`else
   assign irq      = 1'b0;
   assign irqen_rd = 8'h00;
`endif

   assign status = {tx_busy, ovf, perr, ferr, rx_full, !rx_empty, tx_empty, tx_full};

   always_comb begin
      in_port = 8'h00;
      if (hit) begin
         case (offset[1:0])
            2'd0:    in_port = rx_empty ? 8'h00 : rx_head;
            2'd1:    in_port = ctrl;
            2'd2:    in_port = status;
            default: in_port = irqen_rd;
         endcase
      end
   end
endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Register-mapped UART peripheral for the PicoBlaze-style port bus, successor to the fixed single-byte UART top level. It adds run-time programmable frame/baud control, parametrised TX and RX FIFOs, a status register with sticky error flags, and internal loopback. It sits directly on the port_id/out_port/strobe bus and drives the board tx/rx pins.

Parameters:
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, 2..64.
BASE_ADDR, 16'h0000, port_id of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
DIV_W, 19, width of the bit-period counter; must hold 333_333.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
port_id  input  16  register address
out_port  input  8  write data
write_strobe  input  1  one-cycle write qualifier
read_strobe  input  1  one-cycle read qualifier; read side effects occur on this cycle
in_port  output  8  combinational read data for the addressed register, or 0 if no register is addressed
rx  input  1  serial input, asynchronous
tx  output  1  serial output, idle high
irq  output  1  level interrupt (see Optional Feature)

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0 DATA: a write pushes TX FIFO; a read returns the RX FIFO head and pops it. An empty-FIFO read returns 0 with no pop.
  - +1 CTRL (R/W): [3:0] baud, [4] eight, [5] pen, [6] ohel (1 = odd parity), [7] loop.
  - +2 STATUS (RO): [0] tx_full, [1] tx_empty, [2] rx_nempty, [3] rx_full, [4] ferr, [5] perr, [6] ovf, [7] tx_busy. A read clears bits 4-6 on that cycle. A flag set in the same cycle as the read wins.
  - +3 IRQEN (R/W): [0] rx_nempty, [1] tx_empty, [2] error.
- Reset values: tx=1, irq=0, CTRL=8'h14 (baud 4, eight=1), IRQEN=0, FIFOs empty, flags 0, both FSMs IDLE.
- Baud index to k (clocks per bit): 0→333333, 1→83333, 2→41667, 3→20833, 4→10417, 5→5208, 6→2604, 7→1736, 8→868, 9→434, 10→217, 11→109; 12-15→10417.
- Frame format: start(0), data LSB-first (8 bits if eight, else 7), optional parity bit, 1 stop bit(1).
  - Parity is even when ohel=0, odd when ohel=1, computed over the transmitted data bits only.
- Latching: CTRL fields are latched by each FSM at frame start. A mid-frame CTRL write affects the next frame only.
- FIFOs:
  - Binary pointers of width log2(FIFO_DEPTH)+1.
  - A push when full is dropped. For TX this sets ovf; for RX it also sets ovf and discards the received byte.
  - Simultaneous push and pop is legal in every state, including full (count unchanged) and empty with push (pop ignored, push happens).
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE→START when the FIFO is not empty. The FSM pops the FIFO and loads the shift register in the same cycle.
  - Each state lasts exactly k clocks. DATA runs 7/8 bits. PARITY is skipped if !pen. STOP→START back-to-back if the FIFO is not empty, else IDLE.
  - The first start bit appears on tx 1 clk after the DATA write.
  - tx_busy = state != IDLE. tx_empty = FIFO empty && !tx_busy.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - rx passes through a 2-FF synchroniser.
  - IDLE→START on a falling edge. The line is resampled at k/2 (integer divide); if high, the FSM returns to IDLE (false start, no flags).
  - Further samples are taken every k clocks.
  - In 7-bit mode bit 7 is pushed as 0.
  - A parity mismatch sets perr. A stop sample of 0 sets ferr. The byte is still pushed on perr/ferr.
  - The push occurs on the stop-sample cycle. The FSM then returns to IDLE, and a new start edge is accepted from the next cycle.
- Loopback (loop=1): the RX synchroniser input is the internal TX serial output; the tx pin is held 1.
- A reset asserted mid-frame aborts immediately to the reset values. The asynchronous assert is allowed; deassertion must be synchronous to clk.

Optional Feature:
UART_IRQ_EN: when defined, irq = (IRQEN[0]&rx_nempty) | (IRQEN[1]&tx_empty) | (IRQEN[2]&(ferr|perr|ovf)), registered, with 1 clk latency. When undefined, irq is tied 0, the IRQEN register does not exist, and reads of +3 return 0.

Test Plan:
- Reset → tx=1, STATUS=8'h02, CTRL=8'h14, in_port=0 with no read.
- CTRL=8'h3B (baud 11, 8N... pen=1, even), loop=0; write DATA=8'hA5 → tx shows 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 109 clks; tx_busy high for 11×109 clks.
- CTRL=8'hBB (loopback, even parity), write 8'h3C,8'hC3 → RX FIFO holds 3C then C3; two DATA reads return them; STATUS[4:6]=0.
- Drive rx at k=109 with byte 8'h55 and a bad parity bit, then a frame with stop=0 → STATUS reads 8'h34 (rx_nempty|ferr|perr); a second read shows bits 4-6 cleared.
- Loopback, write FIFO_DEPTH+2 bytes without reading RX → ovf set; RX FIFO contains the first FIFO_DEPTH bytes in order.
- UART_IRQ_EN defined, IRQEN=1, loopback send 8'h81 → irq rises 1 clk after rx_nempty; DATA read → irq falls the next clk.
